// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator (master) and the pixel generator / DAC side (slave).
// No handshake: p_tick marks each new (pixel_x, pixel_y); colour inputs are consumed combinationally.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int COLOR_W = 4
);
  logic               pattern_en;
  logic [COLOR_W-1:0] r_in;
  logic [COLOR_W-1:0] g_in;
  logic [COLOR_W-1:0] b_in;
  logic               p_tick;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               line_tick;
  logic               frame_tick;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;

  modport master (
    input  pattern_en, r_in, g_in, b_in,
    output p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
           line_tick, frame_tick, r, g, b
  );

  modport slave (
    output pattern_en, r_in, g_in, b_in,
    input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
           line_tick, frame_tick, r, g, b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider and colour gating.
// Optional colour-bar test pattern is built only when VGA_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10,
  parameter int COLOR_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  // Region bounds carry one extra bit so a total of exactly 2^CNT_W still fits.
  localparam logic [CNT_W:0]   H_ACT_END  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   H_SYNC_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   H_SYNC_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   V_ACT_END  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   V_SYNC_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   V_SYNC_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;
  logic             h_wrap, v_wrap;
  logic [CNT_W:0]   h_ext, v_ext;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    p_tick_d     = (div_cnt_d == DIV_LAST);
    h_d          = h_q;
    v_d          = v_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    video_on_d   = video_on_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    h_ext        = '0;
    v_ext        = '0;

    if (p_tick_q) begin
      if (h_wrap) begin
        h_d         = '0;
        line_tick_d = 1'b1;
        if (v_wrap) begin
          v_d          = '0;
          frame_tick_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end

      // Decode from the next position so the registered flags line up with pixel_x/pixel_y.
      h_ext      = {1'b0, h_d};
      v_ext      = {1'b0, v_d};
      video_on_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
      hsync_d    = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? H_POL : ~H_POL;
      vsync_d    = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? V_POL : ~V_POL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      p_tick_q     <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      video_on_q   <= 1'b0;
      hsync_q      <= ~H_POL;
      vsync_q      <= ~V_POL;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      p_tick_q     <= p_tick_d;
      h_q          <= h_d;
      v_q          <= v_d;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;

  // Eight bars left to right; the last bar absorbs any remainder of H_ACTIVE/8.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, h_q} >= (CNT_W+1)'(k * BAR_W)) bar_idx = 3'(k);
    end
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    src_r = vga.r_in;
    src_g = vga.g_in;
    src_b = vga.b_in;
    if (vga.pattern_en) begin
      src_r = {COLOR_W{bar_rgb[2]}};
      src_g = {COLOR_W{bar_rgb[1]}};
      src_b = {COLOR_W{bar_rgb[0]}};
    end
  end
`else
  logic unused_pattern_en;
  assign unused_pattern_en = vga.pattern_en;

  always_comb begin
    src_r = vga.r_in;
    src_g = vga.g_in;
    src_b = vga.b_in;
  end
`endif

  assign vga.p_tick     = p_tick_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.pixel_x    = h_q;
  assign vga.pixel_y    = v_q;
  assign vga.line_tick  = line_tick_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.r          = video_on_q ? src_r : '0;
  assign vga.g          = video_on_q ? src_g : '0;
  assign vga.b          = video_on_q ? src_b : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance, a tiny 8x6 raster and a
// 12x525 raster for the vertical boundaries within a short run.
`define SNAP(i) {i.p_tick, i.line_tick, i.frame_tick, i.video_on, i.hsync, i.vsync, i.pixel_x, i.pixel_y, i.r, i.g, i.b}

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  vga_timing_gen_if #(.CNT_W(10), .COLOR_W(4)) ifa ();
  vga_timing_gen_if #(.CNT_W(10), .COLOR_W(4)) ifb ();
  vga_timing_gen_if #(.CNT_W(10), .COLOR_W(4)) ifc ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (ifa)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (ifb)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) dut_c (
    .clk   (clk),
    .reset (rst_c),
    .vga   (ifc)
  );

  // Packs expected values in the same field order as SNAP.
  function automatic logic [37:0] pk(logic p, logic lt, logic ft, logic vo, logic hs, logic vs,
                                     int x, int y, logic [3:0] r, logic [3:0] g, logic [3:0] b);
    return {p, lt, ft, vo, hs, vs, 10'(x), 10'(y), r, g, b};
  endfunction

  task automatic test_reset();
    logic [37:0] got, exp;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(negedge clk);
    exp = pk(0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0);
    got = `SNAP(ifa);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", got, exp);
    end
    exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    got = `SNAP(ifb);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_b got=%h exp=%h", got, exp);
    end
    exp = pk(0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0);
    got = `SNAP(ifc);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_c got=%h exp=%h", got, exp);
    end
  endtask

  // Default instance, first three lines after reset: k counts clk edges since release.
  task automatic test_raster_a();
    logic [37:0] got, exp;
    logic [3:0]  c;
    logic        vo;
    int          h, v, first_lt, second_lt;
    first_lt  = -1;
    second_lt = -1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 1; k <= 3 * 3200 + 20; k++) begin
      @(negedge clk);
      h  = (k / 4) % 800;
      v  = (k / 4) / 800;
      vo = (k >= 4) && (h < 640) && (v < 480);
      c  = vo ? 4'hA : 4'h0;
      exp = pk((k % 4) == 3, (k % 3200) == 0, 1'b0, vo, !((h >= 656) && (h <= 751)), 1'b1,
               h, v, c, c, c);
      got = `SNAP(ifa);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL raster_a k=%0d got=%h exp=%h", k, got, exp);
      end
      if (ifa.line_tick === 1'b1) begin
        if (first_lt < 0) first_lt = k;
        else if (second_lt < 0) second_lt = k;
      end
    end
    checks++;
    if (first_lt != 3200 || second_lt != 6400) begin
      errors++;
      $display("FAIL line_period first=%0d second=%0d exp 3200/6400", first_lt, second_lt);
    end
  endtask

  task automatic test_mid_reset();
    logic [37:0] got, exp;
    logic [3:0]  c;
    logic        vo;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (7600) @(negedge clk);
    exp = pk(0, 0, 0, 1, 1, 1, 300, 2, 4'hA, 4'hA, 4'hA);
    got = `SNAP(ifa);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pre_reset_pos got=%h exp=%h", got, exp);
    end
    rst_a = 1'b1;
    #1;
    exp = pk(0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0);
    got = `SNAP(ifa);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_immediate got=%h exp=%h", got, exp);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = `SNAP(ifa);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, exp);
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vo  = (k >= 4);
      c   = vo ? 4'hA : 4'h0;
      exp = pk((k % 4) == 3, 1'b0, 1'b0, vo, 1'b1, 1'b1, k / 4, 0, c, c, c);
      got = `SNAP(ifa);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_reset k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_pattern();
    logic [21:0] got, exp;
    logic [3:0]  er, eg, eb;
    logic        vo;
    int          h;
`ifdef VGA_PATTERN_EN
    logic [2:0] bars [8];
    int         bar;
    bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
`endif
    rst_a = 1'b1;
    ifa.pattern_en = 1'b1;
    ifa.r_in = 4'h5;
    ifa.g_in = 4'h6;
    ifa.b_in = 4'h7;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 1; k <= 3220; k++) begin
      @(negedge clk);
      h  = (k / 4) % 800;
      vo = (k >= 4) && (h < 640);
`ifdef VGA_PATTERN_EN
      bar = h / 80;
      if (bar > 7) bar = 7;
      er = {4{bars[bar][2]}};
      eg = {4{bars[bar][1]}};
      eb = {4{bars[bar][0]}};
`else
      er = 4'h5;
      eg = 4'h6;
      eb = 4'h7;
`endif
      if (!vo) begin
        er = 4'h0;
        eg = 4'h0;
        eb = 4'h0;
      end
      exp = {10'(h), er, eg, eb};
      got = {ifa.pixel_x, ifa.r, ifa.g, ifa.b};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL colour_src k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    ifa.pattern_en = 1'b0;
  endtask

  // 8x6 raster, active-high syncs, one pixel per clk.
  task automatic test_small();
    logic [37:0] got, exp;
    logic [3:0]  c;
    logic        vo;
    int          n, h, v;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      n   = k - 1;
      h   = n % 8;
      v   = (n / 8) % 6;
      vo  = (n >= 1) && (h < 4) && (v < 3);
      c   = vo ? 4'hC : 4'h0;
      exp = pk(1'b1, (n > 0) && ((n % 8) == 0), (n > 0) && ((n % 48) == 0), vo,
               (h >= 5) && (h <= 6), (v == 4), h, v, c, c, c);
      got = `SNAP(ifb);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL small k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  // 12x525 raster: vertical active/blank boundary and vsync at full default height.
  task automatic test_tall();
    logic [37:0] got, exp;
    logic [31:0] e;
    logic [3:0]  c;
    logic        vo;
    int          n, h, v;
    exp_q.delete();
    exp_q.push_back(32'd6301);
    exp_q.push_back(32'd12601);
    @(negedge clk);
    rst_c = 1'b0;
    for (int k = 1; k <= 12610; k++) begin
      @(negedge clk);
      n   = k - 1;
      h   = n % 12;
      v   = (n / 12) % 525;
      vo  = (n >= 1) && (h < 8) && (v < 480);
      c   = vo ? 4'hA : 4'h0;
      exp = pk(1'b1, (n > 0) && ((n % 12) == 0), (n > 0) && ((n % 6300) == 0), vo,
               !((h >= 9) && (h <= 10)), !((v >= 490) && (v <= 491)), h, v, c, c, c);
      got = `SNAP(ifc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL tall k=%0d got=%h exp=%h", k, got, exp);
      end
      if (ifc.frame_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_tick_extra k=%0d exp none", k);
        end else begin
          e = exp_q.pop_front();
          if (e !== 32'(k)) begin
            errors++;
            $display("FAIL frame_tick_time got=%0d exp=%0d", k, e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_tick_missing got=%0d pending exp=0", exp_q.size());
    end
  endtask

  initial begin
    ifa.pattern_en = 1'b0;
    ifa.r_in = 4'hA;
    ifa.g_in = 4'hA;
    ifa.b_in = 4'hA;
    ifb.pattern_en = 1'b0;
    ifb.r_in = 4'hC;
    ifb.g_in = 4'hC;
    ifb.b_in = 4'hC;
    ifc.pattern_en = 1'b0;
    ifc.r_in = 4'hA;
    ifc.g_in = 4'hA;
    ifc.b_in = 4'hA;

    test_reset();
    test_raster_a();
    test_mid_reset();
    test_pattern();
    test_small();
    test_tall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
